// File: rtl/irq_arb_pkg.sv
// Shared definitions for the interrupt one-hot arbiter: request count,
// encoder index width and the two-state FSM encoding.
package irq_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbState_e;

endpackage

// File: rtl/irq_edge_sync.sv
// Single-bit synchroniser followed by a delay flop; emits a registered
// one-cycle pulse for every rising edge seen on the asynchronous input.
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic evtPulse_o
);

  logic [SYNC_STAGES-1:0] syncChain_q;
  logic                   syncDly_q;
  logic                   evtPulse_q;

  // A level held high across reset still yields one event, since the chain
  // restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncChain_q <= '0;
      syncDly_q   <= 1'b0;
      evtPulse_q  <= 1'b0;
    end else begin
      syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], req_i};
      syncDly_q   <= syncChain_q[SYNC_STAGES-1];
      evtPulse_q  <= syncChain_q[SYNC_STAGES-1] & ~syncDly_q;
    end
  end

  assign evtPulse_o = evtPulse_q;

endmodule

// File: rtl/irq_onehot_arbiter.sv
// Captures rising edges on N async request lines and hands one pending line
// at a time to the encoder as a one-hot grant with a valid/ready handshake.
// Optional round-robin selection is enabled with IRQ_ARB_ROUND_ROBIN_EN;
// the default build uses fixed highest-index priority.
module irq_onehot_arbiter
  import irq_arb_pkg::*;
#(
  parameter int N           = N_REQ,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         grant_ready,
  input  logic         ovf_clr,
  output logic [N-1:0] grant_onehot,
  output logic         grant_valid,
  output logic [N-1:0] pending,
  output logic [N-1:0] overflow
);

  logic [N-1:0] reqEvent;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] overflow_q, overflow_d;
  logic [N-1:0] grantOnehot_q, grantOnehot_d;
  logic         grantValid_q, grantValid_d;
  logic [N-1:0] grantClr;
  logic         handshake;
  arbState_e    state_q, state_d;

  for (genvar i = 0; i < N; i++) begin : g_sync
    irq_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req[i]),
      .evtPulse_o(reqEvent[i])
    );
  end

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rrPtr_q, rrPtr_d;

  function automatic logic [IDX_W-1:0] onehotToIdx(input logic [N-1:0] g);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Search upward from the pointer with wrap; first pending bit wins.
  function automatic logic [N-1:0] selectGrant(input logic [N-1:0]     p,
                                               input logic [IDX_W-1:0] ptr);
    logic [N-1:0]     g;
    logic             found;
    logic [IDX_W-1:0] idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && p[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (handshake) rrPtr_d = onehotToIdx(grantOnehot_q) + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rrPtr_q <= '0;
    else        rrPtr_q <= rrPtr_d;
  end
`else
  function automatic logic [N-1:0] selectGrant(input logic [N-1:0] p);
    logic [N-1:0] g;
    g = '0;
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction
`endif

  // A new event on a bit being cleared this cycle re-sets it without overflow.
  always_comb begin
    handshake     = grantValid_q & grant_ready;
    grantClr      = handshake ? grantOnehot_q : '0;
    pending_d     = (pending_q & ~grantClr) | reqEvent;
    overflow_d    = (ovf_clr ? '0 : overflow_q) | (reqEvent & pending_q & ~grantClr);
    state_d       = state_q;
    grantOnehot_d = grantOnehot_q;
    grantValid_d  = grantValid_q;
    case (state_q)
      IDLE: begin
        grantOnehot_d = '0;
        grantValid_d  = 1'b0;
        if (|pending_q) begin
`ifdef IRQ_ARB_ROUND_ROBIN_EN
          grantOnehot_d = selectGrant(pending_q, rrPtr_q);
`else
          grantOnehot_d = selectGrant(pending_q);
`endif
          grantValid_d  = 1'b1;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (handshake) begin
          grantOnehot_d = '0;
          grantValid_d  = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        grantOnehot_d = '0;
        grantValid_d  = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      overflow_q    <= '0;
      grantOnehot_q <= '0;
      grantValid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      grantOnehot_q <= grantOnehot_d;
      grantValid_q  <= grantValid_d;
    end
  end

  assign grant_onehot = grantOnehot_q;
  assign grant_valid  = grantValid_q;
  assign pending      = pending_q;
  assign overflow     = overflow_q;

endmodule
